// File: rtl/abs_diff_sad.sv
// abs_diff_sad: streaming |a-b| with per-frame sum and max over LEN samples.
// A valid/ready input stage feeds a one-pair difference register (stage 1).
// Stage 2 accumulates the sum and tracks the maximum. Each result is held
// in HOLD until the consumer takes it.
// Optional feature macro: ABS_DIFF_SAD_APPROX_EN builds the LSB-truncated
// approximate path and the per-frame mode latch. Without it, only the exact
// difference is built and out_mode is tied to 0.
module abs_diff_sad #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned LEN   = 16,
  parameter  int unsigned L     = 2,
  localparam int unsigned ACC_W = W + $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [W-1:0]     out_max,
  output logic             out_mode
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LEN  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [W-1:0]       d1_q, d1_d;
  logic               d1_v_q, d1_v_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [W-1:0]       max_q, max_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [W-1:0]       out_max_q, out_max_d;

  logic               accept_c;
  logic [W-1:0]       d_exact_c;
  logic [W-1:0]       d_c;

  assign accept_c = in_valid && in_ready_q;

  // Exact absolute difference of the incoming pair
  always_comb begin
    d_exact_c = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);
  end

`ifdef ABS_DIFF_SAD_APPROX_EN
  logic               mode_lat_q, mode_lat_d;
  logic               out_mode_q, out_mode_d;
  logic               eff_mode_c;
  logic [W-1:0]       a_t_c, b_t_c, d_t_c;

  // Approximate difference on truncated operands; the first pair of a frame
  // uses the live mode, later pairs use the latched frame mode
  always_comb begin
    a_t_c      = in_a >> L;
    b_t_c      = in_b >> L;
    d_t_c      = (a_t_c >= b_t_c) ? (a_t_c - b_t_c) : (b_t_c - a_t_c);
    eff_mode_c = (in_cnt_q == '0) ? mode : mode_lat_q;
    d_c        = eff_mode_c ? (d_t_c << L) : d_exact_c;
  end

  // Frame mode latch and output mode register
  always_comb begin
    mode_lat_d = mode_lat_q;
    out_mode_d = out_mode_q;
    if (accept_c && (in_cnt_q == '0)) begin
      mode_lat_d = mode;
    end
    if ((state_q == ACCUM) && d1_v_q && (acc_cnt_q == CNT_LAST)) begin
      out_mode_d = mode_lat_q;
    end
  end

  // Mode state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_lat_q <= 1'b0;
      out_mode_q <= 1'b0;
    end else begin
      mode_lat_q <= mode_lat_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign out_mode = out_mode_q;
`else
  logic unused_c;

  // Exact-only build: mode and the truncation width have no effect
  always_comb begin
    d_c      = d_exact_c;
    unused_c = ^{mode, 1'(L)};
  end

  assign out_mode = 1'b0;
`endif

  // Next-state: stage 1 capture, stage 2 accumulate, frame FSM
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    d1_d        = d1_q;
    d1_v_d      = accept_c;
    acc_d       = acc_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;

    if (accept_c) begin
      d1_d     = d_c;
      in_cnt_d = in_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ACCUM: begin
        if (d1_v_q) begin
          acc_d     = acc_q + ACC_W'(d1_q);
          max_d     = (d1_q > max_q) ? d1_q : max_q;
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == CNT_LAST) begin
            out_sum_d   = acc_d;
            out_max_d   = max_d;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          max_d       = '0;
          in_cnt_d    = '0;
          acc_cnt_d   = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Registered ready: equals the ACCUM/not-full condition of the current state
    in_ready_d = (state_d == ACCUM) && (in_cnt_d != CNT_LEN);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      d1_q        <= '0;
      d1_v_q      <= 1'b0;
      acc_q       <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      d1_q        <= d1_d;
      d1_v_q      <= d1_v_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_abs_diff_sad.sv
// Bench for abs_diff_sad (W=8, LEN=4, L=2). Honours ABS_DIFF_SAD_APPROX_EN.
module tb_abs_diff_sad;

  localparam int W     = 8;
  localparam int LEN   = 4;
  localparam int L     = 2;
  localparam int ACC_W = W + $clog2(LEN);
`ifdef ABS_DIFF_SAD_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  logic             clk, rst_n;
  logic             in_valid, in_ready;
  logic [W-1:0]     in_a, in_b;
  logic             mode;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [W-1:0]     out_max;
  logic             out_mode;

  abs_diff_sad #(.W(W), .LEN(LEN), .L(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_max(out_max), .out_mode(out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fa[LEN];
  int fb[LEN];

  typedef struct packed {
    logic [LEN*W-1:0] a;
    logic [LEN*W-1:0] b;
    logic             m;
    logic [ACC_W-1:0] s;
    logic [W-1:0]     mx;
    logic             md;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: |a-b|, or |a/2^L - b/2^L| * 2^L in approximate mode
  function automatic int diff_m(input int a, input int b, input bit m);
    int x, y;
    if (m) begin
      x = a / (2 ** L);
      y = b / (2 ** L);
      return ((x > y) ? x - y : y - x) * (2 ** L);
    end
    return (a > b) ? a - b : b - a;
  endfunction

  // Drive one pair from a negedge; return at the negedge after acceptance
  task automatic send(input int a, input int b, input bit m, input int gap);
    int n = 0;
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    mode = m;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("send_timeout", 0, 1);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Send fa/fb as one frame and check the result and its handshake timing
  task automatic run_frame(input string nm, input bit m0, input bit toggle,
                           input int gap_kind, input int hold,
                           input int es, input int em, input int emd);
    int g;
    for (int i = 0; i < LEN; i++) begin
      g = 0;
      if (i != LEN - 1) begin
        if (gap_kind == 1) g = (i % 3) + 1;
        else if (gap_kind == 2) g = $urandom_range(0, 2);
      end
      send(fa[i], fb[i], (toggle && i > 0) ? ~m0 : m0, g);
    end
    check({nm, "_valid_early"}, int'(out_valid), 0);
    @(negedge clk);
    check({nm, "_valid"}, int'(out_valid), 1);
    check({nm, "_sum"}, int'(out_sum), es);
    check({nm, "_max"}, int'(out_max), em);
    check({nm, "_mode"}, int'(out_mode), emd);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, int'(out_valid), 1);
      check({nm, "_hold_sum"}, int'(out_sum), es);
      check({nm, "_hold_max"}, int'(out_max), em);
      check({nm, "_hold_mode"}, int'(out_mode), emd);
      check({nm, "_hold_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_valid_drop"}, int'(out_valid), 0);
    check({nm, "_ready_back"}, int'(in_ready), 1);
  endtask

  task automatic load_plan_pairs();
    fa[0] = 10;  fb[0] = 3;
    fa[1] = 3;   fb[1] = 10;
    fa[2] = 255; fb[2] = 0;
    fa[3] = 7;   fb[3] = 7;
  endtask

  initial begin
    int es, em, bm;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    mode = 1'b0; out_ready = 1'b1;

    tbl[0] = '{a: {8'd7, 8'd255, 8'd3, 8'd10}, b: {8'd7, 8'd0, 8'd10, 8'd3},
               m: 1'b0, s: 10'd269, mx: 8'd255, md: 1'b0};
    tbl[1] = '{a: {8'd7, 8'd255, 8'd3, 8'd10}, b: {8'd7, 8'd0, 8'd10, 8'd3},
               m: 1'b1, s: APPROX ? 10'd268 : 10'd269,
               mx: APPROX ? 8'd252 : 8'd255, md: APPROX};
    tbl[2] = '{a: {8'd1, 8'd1, 8'd1, 8'd1}, b: {8'd0, 8'd0, 8'd0, 8'd0},
               m: 1'b0, s: 10'd4, mx: 8'd1, md: 1'b0};
    tbl[3] = '{a: {8'd1, 8'd1, 8'd1, 8'd1}, b: {8'd0, 8'd0, 8'd0, 8'd0},
               m: 1'b1, s: APPROX ? 10'd0 : 10'd4,
               mx: APPROX ? 8'd0 : 8'd1, md: APPROX};
    tbl[4] = '{a: {8'd0, 8'd0, 8'd0, 8'd0}, b: {8'd255, 8'd255, 8'd255, 8'd255},
               m: 1'b1, s: APPROX ? 10'd1008 : 10'd1020,
               mx: APPROX ? 8'd252 : 8'd255, md: APPROX};
    tbl[5] = '{a: {8'd200, 8'd2, 8'd0, 8'd100}, b: {8'd50, 8'd0, 8'd1, 8'd100},
               m: 1'b0, s: 10'd153, mx: 8'd150, md: 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_max", int'(out_max), 0);
    check("rst_out_mode", int'(out_mode), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);
    check("rel_out_valid", int'(out_valid), 0);

    // Table vectors
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < LEN; i++) begin
        fa[i] = int'(tbl[t].a[i*W +: W]);
        fb[i] = int'(tbl[t].b[i*W +: W]);
      end
      run_frame($sformatf("vec%0d", t), tbl[t].m, 1'b0, 0, 0,
                int'(tbl[t].s), int'(tbl[t].mx), int'(tbl[t].md));
    end

    // Backpressure: consumer stalls five cycles
    load_plan_pairs();
    out_ready = 1'b0;
    run_frame("bp", 1'b0, 1'b0, 0, 5, 269, 255, 0);

    // Mode toggled mid-frame is ignored; next frame uses its own start mode
    run_frame("toggle", 1'b0, 1'b1, 0, 0, 269, 255, 0);
    run_frame("toggle_next", 1'b1, 1'b0, 0, 0,
              APPROX ? 268 : 269, APPROX ? 252 : 255, int'(APPROX));

    // Gaps of 1..3 cycles between pairs
    run_frame("gaps", 1'b0, 1'b0, 1, 0, 269, 255, 0);

    // Reset in the middle of a frame
    send(200, 0, 1'b0, 0);
    send(0, 200, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sum", int'(out_sum), 0);
    check("midrst_out_max", int'(out_max), 0);
    check("midrst_out_mode", int'(out_mode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      fa[i] = 1;
      fb[i] = 0;
    end
    run_frame("post_rst", 1'b0, 1'b0, 0, 0, 4, 1, 0);

    // Randomized frames against the reference model
    for (int r = 0; r < 20; r++) begin
      bm = int'($urandom_range(0, 1));
      es = 0;
      em = 0;
      for (int i = 0; i < LEN; i++) begin
        fa[i] = int'($urandom_range(0, 255));
        fb[i] = int'($urandom_range(0, 255));
        es += diff_m(fa[i], fb[i], APPROX && (bm != 0));
        if (diff_m(fa[i], fb[i], APPROX && (bm != 0)) > em)
          em = diff_m(fa[i], fb[i], APPROX && (bm != 0));
      end
      run_frame($sformatf("rand%0d", r), bm[0], 1'b0, 2, 0, es, em,
                (APPROX && bm != 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
